// File: rtl/sprite_renderer.sv
// Sprite pixel writer: walks a W x H mask one pixel per clock and drives the
// VGA adapter's pixel-write port, clipping anything outside the 160x120 frame.
module sprite_renderer #(
  parameter int              W         = 8,
  parameter int              H         = 8,
  parameter logic [W*H-1:0]  SPRITE    = '1,
  parameter logic [2:0]      FG_COLOUR = 3'b111,
  parameter logic [2:0]      BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req,
  input  logic       erase,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] COL_LAST = 4'(W - 1);
  localparam logic [3:0] ROW_LAST = 4'(H - 1);

  state_t          state, state_next;
  logic [7:0]      base_x;
  logic [6:0]      base_y;
  logic            erase_q;
  logic [3:0]      col, row;
  logic            last_col, last_pixel;
  logic [8:0]      sx;
  logic [7:0]      sy;
  logic [8:0]      pix_idx;
  logic [W*H-1:0]  pix_sel;
  logic            opaque;

  assign last_col   = (col == COL_LAST);
  assign last_pixel = last_col && (row == ROW_LAST);

  // Screen coordinates are one bit wider than the adapter's so clipping sees overflow.
  assign sx      = {1'b0, base_x} + {5'b0, col};
  assign sy      = {1'b0, base_y} + {4'b0, row};
  assign pix_idx = 9'(row) * 9'(W) + {5'b0, col};
  assign pix_sel = (W*H)'(1) << pix_idx;
  assign opaque  = |(SPRITE & pix_sel);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      base_x  <= '0;
      base_y  <= '0;
      erase_q <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req) begin
            base_x  <= x_in;
            base_y  <= y_in;
            erase_q <= erase;
            col     <= '0;
            row     <= '0;
          end
        end
        RUN: begin
          if (last_pixel) begin
            col <= '0;
            row <= '0;
          end else if (last_col) begin
            col <= '0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_next = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        vga_x      = sx[7:0];
        vga_y      = sy[6:0];
        vga_colour = erase_q ? BG_COLOUR : FG_COLOUR;
        vga_plot   = opaque && (sx < 9'd160) && (sy < 8'd120);
        if (last_pixel) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: two instances (full mask and a mask with holes)
// driven in lockstep, checked per cycle against hand counts and a pixel model.
module tb_sprite_renderer;

  localparam int WD = 8;
  localparam int HT = 8;

  typedef struct {
    logic       er;
    logic [7:0] x;
    logic [6:0] y;
    int         exp_a;
    int         exp_b;
  } job_t;

  logic       clk = 1'b0;
  logic       reset, req, erase;
  logic [7:0] x_in;
  logic [6:0] y_in;

  logic       a_busy, a_done, a_plot, b_busy, b_done, b_plot;
  logic [7:0] a_x, b_x;
  logic [6:0] a_y, b_y;
  logic [2:0] a_colour, b_colour;

  logic [63:0] mask_a;
  logic [63:0] mask_b;
  int n_vec = 0;
  int n_bad = 0;
  int strobes_a, strobes_b;
  job_t jobs[7];

  always #5 clk = ~clk;

  sprite_renderer dut_a (
    .CLOCK_50(clk), .reset(reset), .req(req), .erase(erase),
    .x_in(x_in), .y_in(y_in), .busy(a_busy), .done(a_done),
    .vga_x(a_x), .vga_y(a_y), .vga_colour(a_colour), .vga_plot(a_plot)
  );

  sprite_renderer #(
    .W(WD), .H(HT), .SPRITE(64'hFFFF_FFFF_FFFF_FFFA),
    .FG_COLOUR(3'b100), .BG_COLOUR(3'b011)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .req(req), .erase(erase),
    .x_in(x_in), .y_in(y_in), .busy(b_busy), .done(b_done),
    .vga_x(b_x), .vga_y(b_y), .vga_colour(b_colour), .vga_plot(b_plot)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_plot_a"}, int'(a_plot), 0);
    checkOutput({tag, "_busy_a"}, int'(a_busy), 0);
    checkOutput({tag, "_done_a"}, int'(a_done), 0);
    checkOutput({tag, "_x_a"}, int'(a_x), 0);
    checkOutput({tag, "_y_a"}, int'(a_y), 0);
    checkOutput({tag, "_colour_a"}, int'(a_colour), 0);
    checkOutput({tag, "_plot_b"}, int'(b_plot), 0);
    checkOutput({tag, "_busy_b"}, int'(b_busy), 0);
    checkOutput({tag, "_done_b"}, int'(b_done), 0);
  endtask

  task automatic checkPixel(input int k, input logic [7:0] bx, input logic [6:0] by, input logic er);
    int sx, sy;
    logic in_frame, pa, pb;
    sx = int'(bx) + (k % WD);
    sy = int'(by) + (k / WD);
    in_frame = (sx < 160) && (sy < 120);
    pa = mask_a[k] && in_frame;
    pb = mask_b[k] && in_frame;
    checkOutput($sformatf("plot_a[%0d]", k), int'(a_plot), int'(pa));
    checkOutput($sformatf("plot_b[%0d]", k), int'(b_plot), int'(pb));
    checkOutput($sformatf("x_a[%0d]", k), int'(a_x), sx % 256);
    checkOutput($sformatf("y_a[%0d]", k), int'(a_y), sy % 128);
    checkOutput($sformatf("x_b[%0d]", k), int'(b_x), sx % 256);
    checkOutput($sformatf("y_b[%0d]", k), int'(b_y), sy % 128);
    checkOutput($sformatf("busy_a[%0d]", k), int'(a_busy), 1);
    checkOutput($sformatf("done_a[%0d]", k), int'(a_done), 0);
    checkOutput($sformatf("busy_b[%0d]", k), int'(b_busy), 1);
    checkOutput($sformatf("done_b[%0d]", k), int'(b_done), 0);
    if (pa) checkOutput($sformatf("colour_a[%0d]", k), int'(a_colour), er ? 0 : 7);
    if (pb) checkOutput($sformatf("colour_b[%0d]", k), int'(b_colour), er ? 3 : 4);
    if (a_plot) strobes_a++;
    if (b_plot) strobes_b++;
  endtask

  // Pulse (or hold) req for one job, check every pixel cycle, the done cycle
  // and the first idle cycle; inputs are scrambled mid-job to prove latching.
  task automatic applyStimulus(input logic er, input logic [7:0] x, input logic [6:0] y,
                               input logic keep_req, input int repulse_at);
    strobes_a = 0;
    strobes_b = 0;
    req   = 1'b1;
    erase = er;
    x_in  = x;
    y_in  = y;
    tick();
    for (int k = 0; k < WD*HT; k++) begin
      req   = (k == repulse_at) || keep_req;
      x_in  = ~x;
      y_in  = ~y;
      erase = ~er;
      checkPixel(k, x, y, er);
      tick();
    end
    checkOutput("done_a", int'(a_done), 1);
    checkOutput("done_b", int'(b_done), 1);
    checkOutput("done_busy_a", int'(a_busy), 1);
    checkOutput("done_plot_a", int'(a_plot), 0);
    checkOutput("done_plot_b", int'(b_plot), 0);
    tick();
    checkOutput("after_busy_a", int'(a_busy), 0);
    checkOutput("after_done_a", int'(a_done), 0);
    checkOutput("after_busy_b", int'(b_busy), 0);
    checkOutput("after_plot_a", int'(a_plot), 0);
  endtask

  initial begin
    mask_a = '1;
    mask_b = 64'hFFFF_FFFF_FFFF_FFFA;
    jobs[0] = '{1'b0, 8'd10,  7'd20,  64, 62};
    jobs[1] = '{1'b0, 8'd156, 7'd116, 16, 14};
    jobs[2] = '{1'b1, 8'd40,  7'd50,  64, 62};
    jobs[3] = '{1'b0, 8'd159, 7'd119,  1,  0};
    jobs[4] = '{1'b0, 8'd152, 7'd112, 64, 62};
    jobs[5] = '{1'b1, 8'd155, 7'd0,   40, 38};
    jobs[6] = '{1'b0, 8'd0,   7'd115, 40, 38};

    reset = 1'b1;
    req   = 1'b0;
    erase = 1'b0;
    x_in  = 8'd77;
    y_in  = 7'd33;
    repeat (3) tick();
    checkIdle("reset");
    reset = 1'b0;
    tick();
    checkIdle("idle");

    foreach (jobs[i]) begin
      applyStimulus(jobs[i].er, jobs[i].x, jobs[i].y, 1'b0, -1);
      checkOutput($sformatf("strobes_a_job%0d", i), strobes_a, jobs[i].exp_a);
      checkOutput($sformatf("strobes_b_job%0d", i), strobes_b, jobs[i].exp_b);
    end

    // A second req mid-job must neither queue nor restart the stream.
    applyStimulus(1'b0, 8'd30, 7'd30, 1'b0, 9);
    checkOutput("repulse_strobes_a", strobes_a, 64);
    for (int i = 0; i < 6; i++) begin
      checkOutput("repulse_no_restart", int'(a_busy), 0);
      tick();
    end

    // Reset during pixel 30 aborts the job with no done.
    req   = 1'b1;
    erase = 1'b0;
    x_in  = 8'd60;
    y_in  = 7'd60;
    tick();
    req = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      checkPixel(k, 8'd60, 7'd60, 1'b0);
      if (k == 30) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    checkIdle("abort");
    for (int i = 0; i < 40; i++) begin
      checkOutput("abort_no_done_a", int'(a_done), 0);
      checkOutput("abort_no_busy_b", int'(b_busy), 0);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, -1);
    checkOutput("post_abort_strobes_a", strobes_a, 64);
    checkOutput("post_abort_strobes_b", strobes_b, 62);

    // Held req: back-to-back jobs every 66 cycles, each latching its own inputs.
    applyStimulus(1'b0, 8'd5, 7'd6, 1'b1, -1);
    checkOutput("held0_strobes_a", strobes_a, 64);
    applyStimulus(1'b1, 8'd70, 7'd80, 1'b1, -1);
    checkOutput("held1_strobes_b", strobes_b, 62);
    applyStimulus(1'b0, 8'd100, 7'd90, 1'b0, -1);
    checkOutput("held2_strobes_a", strobes_a, 64);
    tick();
    checkIdle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
